// File: rtl/snn_result_tx.sv
// snn_result_tx: returns SNN classification results to the host over the JTAG mailbox.
// On each iDONE it captures iNEURON, iBALANCE and the start-to-done latency and packs them
// into a 4-word framed record. The host pulls one 32-bit word at a time with a level REQ/ACK
// handshake. Two frame slots (active + pending) absorb back-to-back results. A result that
// fits in neither slot is dropped and counted.
//
// Ports:
//   iCLK       system clock (SNN domain)
//   iRESET     asynchronous, active-high reset
//   iSTART     core start pulse, restarts the latency counter
//   iDONE      core result-valid pulse, captures a frame
//   iNEURON    core output neurons, sampled on iDONE
//   iBALANCE   core balance/debug word, sampled on iDONE
//   iREQ       host word request (level, asynchronous to iCLK)
//   oACK       word acknowledge (level)
//   oDATA      current frame word, stable while oACK=1
//   oWORD_IDX  index of the word on oDATA
//   oVALID     a frame is available in the active slot
//   oDROP_CNT  cumulative dropped results, saturating at 255
module snn_result_tx #(
    parameter int unsigned NUM_NEURONS = 2,
    parameter int unsigned BAL_WIDTH   = 32
) (
    input  logic                   iCLK,
    input  logic                   iRESET,
    input  logic                   iSTART,
    input  logic                   iDONE,
    input  logic [NUM_NEURONS-1:0] iNEURON,
    input  logic [BAL_WIDTH-1:0]   iBALANCE,
    input  logic                   iREQ,
    output logic                   oACK,
    output logic [31:0]            oDATA,
    output logic [1:0]             oWORD_IDX,
    output logic                   oVALID,
    output logic [7:0]             oDROP_CNT
);

    typedef enum logic [1:0] {StIdle, StReady, StAcked} state_t;

    state_t           state;
    logic             reqMeta;
    logic             reqs;
    logic [31:0]      latCnt;
    logic [7:0]       seq;
    logic [7:0]       dropCnt;
    logic [1:0]       wordIdx;
    logic             actFull;
    logic             pendFull;
    logic [3:0][31:0] actFrame;
    logic [3:0][31:0] pendFrame;

    logic [31:0]      latInc;
    logic [31:0]      latCapt;
    logic             consume;
    logic             actFree;
    logic             pendFree;
    logic [3:0][31:0] newFrame;

    always_comb begin
        latInc  = (latCnt == 32'hFFFF_FFFF) ? latCnt : latCnt + 32'd1;
        // The captured count includes the iDONE edge itself; a same-edge start reads 0.
        latCapt = iSTART ? 32'd0 : latInc;
        consume = (state == StAcked) && !reqs && (wordIdx == 2'd3);
        // Slot availability as seen after this edge's consumption/promotion.
        actFree  = !actFull || (consume && !pendFull);
        pendFree = !pendFull || consume;
        newFrame[0] = {8'hA5, seq, dropCnt, 8'(iNEURON)};
        newFrame[1] = 32'(iBALANCE);
        newFrame[2] = latCapt;
        newFrame[3] = newFrame[0] ^ newFrame[1] ^ newFrame[2];
    end

    assign oDROP_CNT = dropCnt;

    // REQ synchronizer
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            reqMeta <= 1'b0;
            reqs    <= 1'b0;
        end else begin
            reqMeta <= iREQ;
            reqs    <= reqMeta;
        end
    end

    // Frame slots, latency counter, sequence and drop counters
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            latCnt    <= 32'd0;
            seq       <= 8'd0;
            dropCnt   <= 8'd0;
            actFull   <= 1'b0;
            pendFull  <= 1'b0;
            actFrame  <= '0;
            pendFrame <= '0;
        end else begin
            latCnt <= latCapt;
            if (consume) begin
                if (pendFull) begin
                    actFrame <= pendFrame;
                    pendFull <= 1'b0;
                end else begin
                    actFull <= 1'b0;
                end
            end
            // Later assignments override the consumption updates above.
            if (iDONE) begin
                if (actFree) begin
                    actFrame <= newFrame;
                    actFull  <= 1'b1;
                    seq      <= seq + 8'd1;
                end else if (pendFree) begin
                    pendFrame <= newFrame;
                    pendFull  <= 1'b1;
                    seq       <= seq + 8'd1;
                end else if (dropCnt != 8'hFF) begin
                    dropCnt <= dropCnt + 8'd1;
                end
            end
        end
    end

    // Host handshake FSM with registered outputs
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state     <= StIdle;
            wordIdx   <= 2'd0;
            oACK      <= 1'b0;
            oDATA     <= 32'd0;
            oWORD_IDX <= 2'd0;
            oVALID    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    oVALID <= 1'b0;
                    if (actFull) begin
                        state  <= StReady;
                        oVALID <= 1'b1;
                    end
                end
                StReady: begin
                    if (reqs) begin
                        oDATA     <= actFrame[wordIdx];
                        oWORD_IDX <= wordIdx;
                        oACK      <= 1'b1;
                        state     <= StAcked;
                    end
                end
                StAcked: begin
                    if (!reqs) begin
                        oACK <= 1'b0;
                        if (wordIdx != 2'd3) begin
                            wordIdx <= wordIdx + 2'd1;
                            state   <= StReady;
                        end else begin
                            wordIdx <= 2'd0;
                            if (pendFull) begin
                                state <= StReady;
                            end else begin
                                state  <= StIdle;
                                oVALID <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_result_tx.sv
module tb_snn_result_tx;

    logic        iCLK = 1'b0;
    logic        iRESET = 1'b1;
    logic        iSTART = 1'b0;
    logic        iDONE = 1'b0;
    logic [1:0]  iNEURON = 2'd0;
    logic [31:0] iBALANCE = 32'd0;
    logic        iREQ = 1'b0;
    logic        oACK;
    logic [31:0] oDATA;
    logic [1:0]  oWORD_IDX;
    logic        oVALID;
    logic [7:0]  oDROP_CNT;

    snn_result_tx #(.NUM_NEURONS(2), .BAL_WIDTH(32)) dut (
        .iCLK      (iCLK),
        .iRESET    (iRESET),
        .iSTART    (iSTART),
        .iDONE     (iDONE),
        .iNEURON   (iNEURON),
        .iBALANCE  (iBALANCE),
        .iREQ      (iREQ),
        .oACK      (oACK),
        .oDATA     (oDATA),
        .oWORD_IDX (oWORD_IDX),
        .oVALID    (oVALID),
        .oDROP_CNT (oDROP_CNT)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon;
    int   nTests = 0;
    int   nFail = 0;
    logic prevAck = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nTests++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic pushWord(input logic [1:0] idx, input logic [31:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic pushFrame(input logic [7:0] seq, input logic [7:0] drop, input logic [7:0] neur,
                             input logic [31:0] bal, input logic [31:0] lat);
        logic [31:0] w0;
        w0 = {8'hA5, seq, drop, neur};
        pushWord(2'd0, w0);
        pushWord(2'd1, bal);
        pushWord(2'd2, lat);
        pushWord(2'd3, w0 ^ bal ^ lat);
    endtask

    // Monitor: every rising oACK must deliver the next expected word.
    always @(negedge iCLK) begin
        if (oACK && !prevAck) begin
            if (sb.size() == 0) begin
                nTests++;
                nFail++;
                $display("FAIL unexpected_word: got idx %0d data %h, required no word",
                         oWORD_IDX, oDATA);
            end else begin
                mon = sb.pop_front();
                chk("word_data", oDATA, mon.data);
                chk("word_idx", 32'(oWORD_IDX), 32'(mon.idx));
            end
        end
        prevAck <= oACK;
    end

    task automatic doReset();
        iRESET = 1'b1;
        iSTART = 1'b0;
        iDONE  = 1'b0;
        iREQ   = 1'b0;
        repeat (2) @(negedge iCLK);
        sb.delete();
        iRESET = 1'b0;
        @(negedge iCLK);
    endtask

    // gap = edges from the iSTART edge to the iDONE edge (0 = same edge)
    task automatic core(input int gap, input logic [1:0] neur, input logic [31:0] bal);
        iNEURON  = neur;
        iBALANCE = bal;
        if (gap == 0) begin
            iSTART = 1'b1;
            iDONE  = 1'b1;
            @(negedge iCLK);
            iSTART = 1'b0;
            iDONE  = 1'b0;
        end else begin
            iSTART = 1'b1;
            @(negedge iCLK);
            iSTART = 1'b0;
            repeat (gap - 1) @(negedge iCLK);
            iDONE = 1'b1;
            @(negedge iCLK);
            iDONE = 1'b0;
        end
    endtask

    task automatic waitAck(input logic lvl);
        int n;
        n = 0;
        while (oACK !== lvl && n < 40) begin
            @(negedge iCLK);
            n++;
        end
        if (oACK !== lvl) begin
            nTests++;
            nFail++;
            $display("FAIL ack_timeout: oACK=%b, required %b", oACK, lvl);
        end
    endtask

    task automatic readWord();
        iREQ = 1'b1;
        waitAck(1'b1);
        iREQ = 1'b0;
        waitAck(1'b0);
    endtask

    task automatic readFrame();
        repeat (4) readWord();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and basic frame
        doReset();
        chk("rst_ack", 32'(oACK), 32'd0);
        chk("rst_data", oDATA, 32'd0);
        chk("rst_idx", 32'(oWORD_IDX), 32'd0);
        chk("rst_valid", 32'(oVALID), 32'd0);
        chk("rst_drop", 32'(oDROP_CNT), 32'd0);
        pushWord(2'd0, 32'hA500_0002);
        pushWord(2'd1, 32'h0000_0123);
        pushWord(2'd2, 32'h0000_000A);
        pushWord(2'd3, 32'hA500_012B);
        core(10, 2'b10, 32'h123);
        readFrame();
        chk("valid_after_w3", 32'(oVALID), 32'd0);

        // Two slots fill, third result dropped
        doReset();
        core(3, 2'd1, 32'h11);
        core(4, 2'd2, 32'h22);
        core(0, 2'd3, 32'h33);
        chk("drop_cnt_one", 32'(oDROP_CNT), 32'd1);
        chk("valid_held", 32'(oVALID), 32'd1);
        pushFrame(8'd0, 8'd0, 8'd1, 32'h11, 32'd3);
        pushFrame(8'd1, 8'd0, 8'd2, 32'h22, 32'd4);
        readFrame();
        readFrame();
        pushFrame(8'd2, 8'd1, 8'd0, 32'h44, 32'd5);
        core(5, 2'd0, 32'h44);
        readFrame();

        // Request held high while idle
        doReset();
        iREQ = 1'b1;
        repeat (6) @(negedge iCLK);
        chk("idle_no_ack", 32'(oACK), 32'd0);
        chk("idle_no_valid", 32'(oVALID), 32'd0);
        pushFrame(8'd0, 8'd0, 8'd3, 32'hABC, 32'd7);
        core(7, 2'd3, 32'hABC);
        @(negedge iCLK);
        chk("valid_rise", 32'(oVALID), 32'd1);
        chk("ack_not_yet", 32'(oACK), 32'd0);
        @(negedge iCLK);
        chk("ack_one_after_valid", 32'(oACK), 32'd1);
        iREQ = 1'b0;
        waitAck(1'b0);
        repeat (3) readWord();

        // iDONE on the w3 consumption edge with pending full
        doReset();
        pushFrame(8'd0, 8'd0, 8'd1, 32'h5A, 32'd0);
        pushFrame(8'd1, 8'd0, 8'd2, 32'h6B, 32'd0);
        pushFrame(8'd2, 8'd0, 8'd3, 32'h7C, 32'd0);
        core(0, 2'd1, 32'h5A);
        core(0, 2'd2, 32'h6B);
        repeat (3) readWord();
        iREQ = 1'b1;
        waitAck(1'b1);
        iREQ = 1'b0;
        @(negedge iCLK);
        @(negedge iCLK);
        iNEURON  = 2'd3;
        iBALANCE = 32'h7C;
        iSTART   = 1'b1;
        iDONE    = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
        iDONE  = 1'b0;
        chk("coincident_consumed", 32'(oACK), 32'd0);
        chk("coincident_no_drop", 32'(oDROP_CNT), 32'd0);
        chk("coincident_valid", 32'(oVALID), 32'd1);
        readFrame();
        readFrame();

        // Latency: same-edge start/done, and saturation
        doReset();
        pushFrame(8'd0, 8'd0, 8'd0, 32'h1, 32'd0);
        core(0, 2'd0, 32'h1);
        readFrame();
        pushFrame(8'd1, 8'd0, 8'd1, 32'h2, 32'hFFFF_FFFF);
        iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
        force dut.latCnt = 32'hFFFF_FFFF;
        repeat (3) @(negedge iCLK);
        iNEURON  = 2'd1;
        iBALANCE = 32'h2;
        iDONE    = 1'b1;
        @(negedge iCLK);
        iDONE = 1'b0;
        release dut.latCnt;
        readFrame();

        // Asynchronous reset while word 2 is acknowledged
        doReset();
        pushFrame(8'd0, 8'd0, 8'd2, 32'h99, 32'd2);
        pushFrame(8'd1, 8'd0, 8'd1, 32'h88, 32'd3);
        core(2, 2'd2, 32'h99);
        core(3, 2'd1, 32'h88);
        core(0, 2'd0, 32'h0);
        repeat (2) readWord();
        iREQ = 1'b1;
        waitAck(1'b1);
        chk("pre_reset_idx", 32'(oWORD_IDX), 32'd2);
        #3;
        iRESET = 1'b1;
        #1;
        chk("async_ack", 32'(oACK), 32'd0);
        chk("async_data", oDATA, 32'd0);
        chk("async_idx", 32'(oWORD_IDX), 32'd0);
        chk("async_valid", 32'(oVALID), 32'd0);
        chk("async_drop", 32'(oDROP_CNT), 32'd0);
        sb.delete();
        iREQ = 1'b0;
        @(negedge iCLK);
        @(negedge iCLK);
        iRESET = 1'b0;
        @(negedge iCLK);
        pushFrame(8'd0, 8'd0, 8'd1, 32'h77, 32'd4);
        core(4, 2'd1, 32'h77);
        readFrame();

        repeat (4) @(negedge iCLK);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
